// File: rtl/radix2_div_seq.sv
// ============================================================================
//  Module      : radix2_div_seq (with helper radix2_linediv)
//  Description : Iterative 32-bit signed/unsigned integer divider. Operands
//                are reduced to magnitudes, divided two quotient bits per
//                cycle over 16 cycles, then sign-corrected. Divide-by-zero
//                and divisor magnitudes >= 2^31 are resolved on the accept
//                edge without iterating.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

// Combinational 2-bit restoring line-division step. The divisor magnitude
// must be below 2^31 so that every partial remainder fits in 31 bits.
module radix2_linediv (
    input  logic [1:0]  iSOURCE_DIVIDEND,
    input  logic [31:0] iSOURCE_DIVISOR,
    input  logic [30:0] iSOURCE_R,
    output logic [1:0]  oOUT_Q,
    output logic [30:0] oOUT_R
);
    logic [31:0] w_t1;
    logic [31:0] w_t2;
    logic        w_q1;
    logic        w_q0;
    logic [30:0] w_r1;
    logic [30:0] w_r2;

    // Two back-to-back shift/compare/subtract steps, high dividend bit first
    always_comb begin
        w_t1   = {iSOURCE_R, iSOURCE_DIVIDEND[1]};
        w_q1   = (w_t1 >= iSOURCE_DIVISOR);
        w_r1   = w_q1 ? 31'(w_t1 - iSOURCE_DIVISOR) : w_t1[30:0];
        w_t2   = {w_r1, iSOURCE_DIVIDEND[0]};
        w_q0   = (w_t2 >= iSOURCE_DIVISOR);
        w_r2   = w_q0 ? 31'(w_t2 - iSOURCE_DIVISOR) : w_t2[30:0];
        oOUT_Q = {w_q1, w_q0};
        oOUT_R = w_r2;
    end
endmodule

module radix2_div_seq (
    input  logic        iCLOCK,
    input  logic        inRESET,
    input  logic        iRESET_SYNC,
    input  logic        iREQ_VALID,
    output logic        oREQ_BUSY,
    input  logic        iREQ_SIGNED,
    input  logic [31:0] iREQ_DIVIDEND,
    input  logic [31:0] iREQ_DIVISOR,
    output logic        oOUT_VALID,
    input  logic        iOUT_BUSY,
    output logic [31:0] oOUT_Q,
    output logic [31:0] oOUT_R,
    output logic        oOUT_DIVZERO
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]  r_state;
    logic        r_busy;
    logic        r_valid;
    logic [31:0] r_shift;
    logic [30:0] r_rem;
    logic [31:0] r_quot;
    logic [3:0]  r_cnt;
    logic [31:0] r_divisor;
    logic        r_negq;
    logic        r_negr;
    logic [31:0] r_q;
    logic [31:0] r_r;
    logic        r_divzero;

    logic [31:0] w_dd_mag;
    logic [31:0] w_dv_mag;
    logic        w_negq_in;
    logic        w_negr_in;
    logic        w_dv_zero;
    logic        w_big_q;
    logic [31:0] w_big_q32;
    logic [31:0] w_big_r;
    logic [31:0] w_sp_q;
    logic [31:0] w_sp_r;
    logic [1:0]  w_step_q;
    logic [30:0] w_step_r;
    logic [31:0] w_quot_next;
    logic [31:0] w_rem_ext;
    logic [31:0] w_fix_q;
    logic [31:0] w_fix_r;

    // Request decode: magnitudes, result signs and the one-shot large-divisor path
    always_comb begin
        w_dd_mag  = (iREQ_SIGNED && iREQ_DIVIDEND[31]) ? (~iREQ_DIVIDEND + 32'd1) : iREQ_DIVIDEND;
        w_dv_mag  = (iREQ_SIGNED && iREQ_DIVISOR[31])  ? (~iREQ_DIVISOR  + 32'd1) : iREQ_DIVISOR;
        w_negq_in = iREQ_SIGNED & (iREQ_DIVIDEND[31] ^ iREQ_DIVISOR[31]);
        w_negr_in = iREQ_SIGNED & iREQ_DIVIDEND[31];
        w_dv_zero = (iREQ_DIVISOR == 32'd0);
        // With |dv| >= 2^31 the quotient can only be 0 or 1
        w_big_q   = (w_dd_mag >= w_dv_mag);
        w_big_q32 = {31'd0, w_big_q};
        w_big_r   = w_big_q ? (w_dd_mag - w_dv_mag) : w_dd_mag;
        w_sp_q    = w_negq_in ? (32'd0 - w_big_q32) : w_big_q32;
        w_sp_r    = w_negr_in ? (32'd0 - w_big_r)   : w_big_r;
    end

    radix2_linediv u_linediv (
        .iSOURCE_DIVIDEND (r_shift[31:30]),
        .iSOURCE_DIVISOR  (r_divisor),
        .iSOURCE_R        (r_rem),
        .oOUT_Q           (w_step_q),
        .oOUT_R           (w_step_r)
    );

    // Final-step results with sign correction, used on the CALC->DONE edge
    always_comb begin
        w_quot_next = {r_quot[29:0], w_step_q};
        w_rem_ext   = {1'b0, w_step_r};
        w_fix_q     = r_negq ? (32'd0 - w_quot_next) : w_quot_next;
        w_fix_r     = r_negr ? (32'd0 - w_rem_ext)   : w_rem_ext;
    end

    // Sequencer: accept, iterate, hold result until consumed; flush wins over all
    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            r_state   <= ST_IDLE;
            r_busy    <= 1'b0;
            r_valid   <= 1'b0;
            r_shift   <= 32'd0;
            r_rem     <= 31'd0;
            r_quot    <= 32'd0;
            r_cnt     <= 4'd0;
            r_divisor <= 32'd0;
            r_negq    <= 1'b0;
            r_negr    <= 1'b0;
            r_q       <= 32'd0;
            r_r       <= 32'd0;
            r_divzero <= 1'b0;
        end else if (iRESET_SYNC) begin
            r_state   <= ST_IDLE;
            r_busy    <= 1'b0;
            r_valid   <= 1'b0;
            r_shift   <= 32'd0;
            r_rem     <= 31'd0;
            r_quot    <= 32'd0;
            r_cnt     <= 4'd0;
            r_divisor <= 32'd0;
            r_negq    <= 1'b0;
            r_negr    <= 1'b0;
            r_q       <= 32'd0;
            r_r       <= 32'd0;
            r_divzero <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (iREQ_VALID) begin
                        r_busy    <= 1'b1;
                        r_negq    <= w_negq_in;
                        r_negr    <= w_negr_in;
                        r_divisor <= w_dv_mag;
                        r_shift   <= w_dd_mag;
                        r_rem     <= 31'd0;
                        r_quot    <= 32'd0;
                        r_cnt     <= 4'd0;
                        if (w_dv_zero) begin
                            r_state   <= ST_DONE;
                            r_valid   <= 1'b1;
                            r_q       <= 32'hFFFF_FFFF;
                            r_r       <= iREQ_DIVIDEND;
                            r_divzero <= 1'b1;
                        end else if (w_dv_mag[31]) begin
                            r_state   <= ST_DONE;
                            r_valid   <= 1'b1;
                            r_q       <= w_sp_q;
                            r_r       <= w_sp_r;
                            r_divzero <= 1'b0;
                        end else begin
                            r_state   <= ST_CALC;
                        end
                    end
                end
                ST_CALC: begin
                    r_shift <= {r_shift[29:0], 2'b00};
                    r_rem   <= w_step_r;
                    r_quot  <= w_quot_next;
                    r_cnt   <= r_cnt + 4'd1;
                    if (r_cnt == 4'd15) begin
                        r_state   <= ST_DONE;
                        r_valid   <= 1'b1;
                        r_q       <= w_fix_q;
                        r_r       <= w_fix_r;
                        r_divzero <= 1'b0;
                    end
                end
                ST_DONE: begin
                    if (!iOUT_BUSY) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign oREQ_BUSY    = r_busy;
    assign oOUT_VALID   = r_valid;
    assign oOUT_Q       = r_q;
    assign oOUT_R       = r_r;
    assign oOUT_DIVZERO = r_divzero;
endmodule

`default_nettype wire

// File: doc/radix2_div_seq.md
# radix2_div_seq

Iterative 32-bit integer divider sequencer for the execute-stage divide unit. Accepts one signed or unsigned divide request, converts operands to magnitudes, and drives the combinational 2-bit line-division step (`radix2_linediv`) for 16 cycles. Each cycle it supplies two dividend bits and the running 31-bit partial remainder, and collects two quotient bits. It then applies sign correction and presents quotient/remainder to the writeback side through a valid/busy handshake.

## Interface
Parameters: none (width fixed at 32).
- iCLOCK  in  1  core clock
- inRESET  in  1  asynchronous reset, active-low
- iRESET_SYNC  in  1  synchronous flush; aborts any operation
- iREQ_VALID  in  1  request strobe
- oREQ_BUSY  out  1  sequencer not idle; request accepted only when 0
- iREQ_SIGNED  in  1  1 = two's-complement operands
- iREQ_DIVIDEND  in  32  dividend
- iREQ_DIVISOR  in  32  divisor
- oOUT_VALID  out  1  result valid
- iOUT_BUSY  in  1  consumer stall; result held while 1
- oOUT_Q  out  32  quotient
- oOUT_R  out  32  remainder
- oOUT_DIVZERO  out  1  divisor was zero

## Operation
- States: IDLE, CALC, DONE. `oREQ_BUSY` = (state != IDLE). `oOUT_VALID` = (state == DONE).
- Accept rule: IDLE and `iREQ_VALID`. The operands are latched on that edge.
  - Magnitudes: |x| = x[31] ? ~x+1 : x in signed mode, x otherwise.
  - Latched sign flags: negQ = signed & (dd[31]^dv[31]); negR = signed & dd[31].
- Special cases are resolved on the accept edge. The state goes IDLE->DONE directly.
  - Divisor == 0: Q = 0xFFFFFFFF, R = raw dividend, DIVZERO = 1. No sign fixup.
  - |divisor|[31] == 1, i.e. magnitude >= 2^31: the line-div step cannot hold the remainder, so compute q = (|dd| >= |dv|), r = |dd| - (q ? |dv| : 0). The sign fixup below is then applied.
- Normal case: IDLE->CALC. Registers are initialised as follows:
  - dividend shift register = |dd|
  - partial remainder R31 = 0
  - quotient register = 0
  - step counter = 0
- Each CALC cycle:
  - Feed `iSOURCE_DIVIDEND` = shift[31:30], `iSOURCE_R` = R31, `iSOURCE_DIVISOR` = |dv|.
  - Update shift <= shift<<2, R31 <= step remainder, quot <= {quot[29:0], step Q[1:0]}, counter++.
- When counter == 15, the same edge moves to DONE and applies the fixup:
  - Q = negQ ? -quot : quot
  - R = negR ? -{1'b0,R31} : {1'b0,R31}
- Overflow case 0x80000000 / 0xFFFFFFFF (signed) gives Q = 0x80000000, R = 0. This falls out of the magnitude path with no special handling.
- DONE: results held stable while `iOUT_BUSY` = 1. The first edge with `iOUT_BUSY` = 0 returns to IDLE. Outputs Q/R/DIVZERO keep their values until the next DONE entry.
- `iRESET_SYNC` has priority over all transitions. It forces IDLE, clears counter/outputs/flags, and drops any in-flight or pending result.
- A request presented while `oREQ_BUSY` = 1 is ignored; the requester must hold it.

## Timing
- Async reset (`inRESET` = 0): state IDLE. `oREQ_BUSY`, `oOUT_VALID`, `oOUT_DIVZERO` = 0. `oOUT_Q`, `oOUT_R` = 0. Internal registers = 0.
- All outputs are registered; there is no combinational path from inputs to outputs.
- Latency, counted from the accept edge to the edge that asserts `oOUT_VALID`:
  - Normal: 16 edges after accept (accept edge plus 16 CALC edges).
  - Special cases: `oOUT_VALID` is high from the accept edge itself.
- `oREQ_BUSY` rises on the accept edge and falls on the edge that consumes the result.
- Minimum request spacing: 18 cycles normal, 2 cycles special (DONE with no stall).
- Reset or flush during CALC: no `oOUT_VALID` pulse from the aborted operation. The next request is accepted on the first IDLE cycle.

## Test plan
- Unsigned 100 / 7 with `iOUT_BUSY` = 0 -> `oOUT_VALID` 16 edges after accept, Q = 14, R = 2, DIVZERO = 0, then IDLE one edge later.
- Signed 0xFFFFFFF9 (-7) / 2 -> Q = 0xFFFFFFFD, R = 0xFFFFFFFF. Signed 7 / 0xFFFFFFFE -> Q = 0xFFFFFFFD, R = 1.
- Divide by zero, 5 / 0 (either mode) -> `oOUT_VALID` on the accept edge, Q = 0xFFFFFFFF, R = 5, DIVZERO = 1.
- Unsigned 0xFFFFFFFF / 0x80000000 -> special path, Q = 1, R = 0x7FFFFFFF. Signed 0x80000000 / 0xFFFFFFFF -> Q = 0x80000000, R = 0.
- Hold `iOUT_BUSY` = 1 for 5 cycles in DONE while a second request is presented -> outputs stable, `oREQ_BUSY` = 1, second request not accepted until IDLE.
- Pulse `iRESET_SYNC` at CALC step 8, and separately drop `inRESET` mid-CALC -> no `oOUT_VALID`, all outputs = 0. A new 0xFFFFFFFF / 3 then completes normally with Q = 0x55555555, R = 0.
